// File: rtl/rdregs_word_packer.sv
// Packs a valid/ready stream of 16-bit halfwords into 32-bit words and
// drives the write port of the 256x32 / 512x16 readback buffer.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start, base_addr    begin a session at base_addr
//   in_valid, in_data   halfword stream (first of a pair -> bits [15:0])
//   in_ready            packer accepts in_data this cycle
//   flush               close the session, writing any partial word
//   wr_ce, wr_addr      32-bit write strobe and word address
//   wr_data             {high halfword, low halfword}
//   word_count          words written since start
//   busy, full, done    session active, buffer full, session-end pulse

module rdregs_word_packer #(
   parameter int          ADDR_W = 8,
   parameter logic [15:0] PAD    = 16'h0000,
   parameter bit          WRAP   = 1'b0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              in_valid,
   input  logic [15:0]       in_data,
   output logic              in_ready,
   input  logic              flush,
   output logic              wr_ce,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [31:0]       wr_data,
   output logic [ADDR_W:0]   word_count,
   output logic              busy,
   output logic              full,
   output logic              done
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LO,
      S_HI,
      S_FULL
   } state_t;

   localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
   localparam logic [ADDR_W:0]   CNT_MAX  = {1'b1, {ADDR_W{1'b0}}};

   state_t            state;
   logic [ADDR_W-1:0] addr;
   logic [15:0]       low;
   logic              done_pend;
   logic [ADDR_W:0]   cnt_next;

   assign busy     = (state == S_LO) || (state == S_HI);
   assign in_ready = busy && !flush && !start;

   // Without wrapping the count stops at the buffer depth.
   always_comb begin
      cnt_next = word_count + 1'b1;
      if (!WRAP && word_count == CNT_MAX)
         cnt_next = word_count;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         addr       <= '0;
         low        <= '0;
         wr_ce      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
         word_count <= '0;
         full       <= 1'b0;
         done       <= 1'b0;
         done_pend  <= 1'b0;
      end else begin
         wr_ce     <= 1'b0;
         // A flush of a partial word signals done one cycle after its write.
         done      <= done_pend;
         done_pend <= 1'b0;
         if (start) begin
            addr       <= base_addr;
            word_count <= '0;
            full       <= 1'b0;
            low        <= '0;
            state      <= S_LO;
         end else begin
            case (state)
               S_LO: begin
                  if (flush) begin
                     done  <= 1'b1;
                     state <= S_IDLE;
                  end else if (in_valid) begin
                     low   <= in_data;
                     state <= S_HI;
                  end
               end
               S_HI: begin
                  if (flush) begin
                     wr_ce      <= 1'b1;
                     wr_addr    <= addr;
                     wr_data    <= {PAD, low};
                     addr       <= addr + 1'b1;
                     word_count <= cnt_next;
                     done_pend  <= 1'b1;
                     state      <= S_IDLE;
                  end else if (in_valid) begin
                     wr_ce      <= 1'b1;
                     wr_addr    <= addr;
                     wr_data    <= {in_data, low};
                     addr       <= addr + 1'b1;
                     word_count <= cnt_next;
                     // Last word of the buffer: stop unless wrapping.
                     if (!WRAP && addr == ADDR_MAX) begin
                        full  <= 1'b1;
                        state <= S_FULL;
                     end else begin
                        state <= S_LO;
                     end
                  end
               end
               S_FULL: begin
                  if (flush) begin
                     done  <= 1'b1;
                     full  <= 1'b0;
                     state <= S_IDLE;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_rdregs_word_packer.sv
// Directed self-checking bench for rdregs_word_packer.
// u0 runs with WRAP=0, u1 with WRAP=1; both share all inputs.

module tb_rdregs_word_packer;

   logic        clk = 1'b0;
   logic        reset, start, in_valid, flush;
   logic [7:0]  base_addr;
   logic [15:0] in_data;

   logic        rdy0, ce0, busy0, full0, done0;
   logic [7:0]  addr0;
   logic [31:0] data0;
   logic [8:0]  cnt0;
   logic        rdy1, ce1, busy1, full1, done1;
   logic [7:0]  addr1;
   logic [31:0] data1;
   logic [8:0]  cnt1;

   int n_checks = 0;
   int n_fail   = 0;
   logic [39:0] q0[$];
   logic [39:0] q1[$];

   always #5 clk = ~clk;

   rdregs_word_packer #(.ADDR_W(8), .PAD(16'h0000), .WRAP(1'b0)) u0 (
      .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
      .in_valid(in_valid), .in_data(in_data), .in_ready(rdy0),
      .flush(flush), .wr_ce(ce0), .wr_addr(addr0), .wr_data(data0),
      .word_count(cnt0), .busy(busy0), .full(full0), .done(done0)
   );

   rdregs_word_packer #(.ADDR_W(8), .PAD(16'h0000), .WRAP(1'b1)) u1 (
      .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
      .in_valid(in_valid), .in_data(in_data), .in_ready(rdy1),
      .flush(flush), .wr_ce(ce1), .wr_addr(addr1), .wr_data(data1),
      .word_count(cnt1), .busy(busy1), .full(full1), .done(done1)
   );

   always @(negedge clk) begin
      if (ce0) q0.push_back({addr0, data0});
      if (ce1) q1.push_back({addr1, data1});
   end

   task automatic check(input string tag, input logic [39:0] got,
                        input logic [39:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [15:0] d);
      in_valid = 1'b1;
      in_data  = d;
      tick();
   endtask

   task automatic go(input logic [7:0] b);
      in_valid  = 1'b0;
      start     = 1'b1;
      base_addr = b;
      #1;
      check("start_rdy", 40'(rdy0), 40'(0));
      tick();
      start = 1'b0;
   endtask

   task automatic do_flush();
      in_valid = 1'b0;
      flush    = 1'b1;
      tick();
      flush = 1'b0;
   endtask

   int idx;

   initial begin
      reset = 1'b1; start = 1'b0; in_valid = 1'b0; flush = 1'b0;
      base_addr = '0; in_data = '0;
      tick(); tick();
      reset = 1'b0;
      #1;
      check("rst_rdy",  40'(rdy0),  40'(0));
      check("rst_ce",   40'(ce0),   40'(0));
      check("rst_addr", 40'(addr0), 40'(0));
      check("rst_data", 40'(data0), 40'(0));
      check("rst_cnt",  40'(cnt0),  40'(0));
      check("rst_flag", 40'({busy0, full0, done0}), 40'(0));

      // back-to-back pairs
      go(8'h10);
      in_valid = 1'b1; #1;
      check("b2b_rdy", 40'(rdy0), 40'(1));
      check("b2b_busy", 40'(busy0), 40'(1));
      push(16'h1111);
      check("b2b_ce0", 40'(ce0), 40'(0));
      push(16'h2222);
      check("b2b_w0", {7'd0, ce0, addr0, data0}, {7'd0, 1'b1, 8'h10, 32'h22221111});
      push(16'h3333);
      check("b2b_ce1", 40'(ce0), 40'(0));
      push(16'h4444);
      in_valid = 1'b0;
      check("b2b_w1", {7'd0, ce0, addr0, data0}, {7'd0, 1'b1, 8'h11, 32'h44443333});
      check("b2b_cnt", 40'(cnt0), 40'(2));
      tick();
      check("b2b_hold", {7'd0, ce0, addr0, data0}, {7'd0, 1'b0, 8'h11, 32'h44443333});

      // partial-word flush
      go(8'h20);
      push(16'hAAAA); push(16'hBBBB); push(16'hCCCC);
      check("fl_w0", {7'd0, ce0, addr0, data0}, {7'd0, 1'b0, 8'h20, 32'hBBBBAAAA});
      do_flush();
      check("fl_w1", {7'd0, ce0, addr0, data0}, {7'd0, 1'b1, 8'h21, 32'h0000CCCC});
      check("fl_cnt", 40'(cnt0), 40'(2));
      check("fl_done0", 40'(done0), 40'(0));
      tick();
      check("fl_done1", 40'({done0, ce0, busy0}), 40'(3'b100));
      in_valid = 1'b1; #1;
      check("fl_rdy", 40'(rdy0), 40'(0));
      tick();
      check("fl_done2", 40'(done0), 40'(0));
      in_valid = 1'b0;

      // full without wrap
      q0.delete();
      go(8'hFE);
      idx = 0;
      for (int c = 0; c < 12; c++) begin
         in_valid = (idx < 6);
         in_data  = 16'hC000 | 16'(idx);
         #1;
         if (in_valid && rdy0) idx++;
         @(posedge clk); #1;
         if (ce0 && addr0 == 8'hFF) check("full_with_ce", 40'(full0), 40'(1));
      end
      check("full_acc", 40'(idx), 40'(4));
      check("full_nq", 40'(q0.size()), 40'(2));
      check("full_q0", q0[0], {8'hFE, 32'hC001C000});
      check("full_q1", q0[1], {8'hFF, 32'hC003C002});
      check("full_flag", 40'({full0, busy0}), 40'(2'b10));
      check("full_cnt", 40'(cnt0), 40'(2));
      in_valid = 1'b1; #1;
      check("full_rdy", 40'(rdy0), 40'(0));
      do_flush();
      check("full_fdone", 40'({done0, full0}), 40'(2'b10));

      // wrap
      q0.delete(); q1.delete();
      go(8'hFF);
      push(16'h0101); push(16'h0202); push(16'h0303); push(16'h0404);
      in_valid = 1'b0;
      tick();
      check("wr_nq", 40'(q1.size()), 40'(2));
      check("wr_q0", q1[0], {8'hFF, 32'h02020101});
      check("wr_q1", q1[1], {8'h00, 32'h04040303});
      check("wr_cnt", 40'(cnt1), 40'(2));
      check("wr_busy", 40'({busy1, full1}), 40'(2'b10));
      check("nw_nq", 40'(q0.size()), 40'(1));
      check("nw_full", 40'(full0), 40'(1));

      // valid toggling
      q0.delete();
      go(8'h10);
      push(16'h1111); in_valid = 1'b0; tick();
      push(16'h2222); in_valid = 1'b0; tick();
      push(16'h3333); in_valid = 1'b0; tick();
      push(16'h4444); in_valid = 1'b0; tick();
      tick();
      check("tg_nq", 40'(q0.size()), 40'(2));
      check("tg_q0", q0[0], {8'h10, 32'h22221111});
      check("tg_q1", q0[1], {8'h11, 32'h44443333});

      // mid-pair restart
      q0.delete();
      go(8'h30);
      push(16'h5555);
      go(8'h40);
      push(16'h6666); push(16'h7777);
      in_valid = 1'b0;
      tick();
      check("mp_nq", 40'(q0.size()), 40'(1));
      check("mp_q0", q0[0], {8'h40, 32'h77776666});
      check("mp_cnt", 40'(cnt0), 40'(1));

      // reset during HI
      go(8'h50);
      push(16'h8888);
      in_valid = 1'b1; in_data = 16'h9999; reset = 1'b1;
      tick();
      reset = 1'b0; in_valid = 1'b0;
      check("rh_ce", 40'(ce0), 40'(0));
      check("rh_out", {ce0, addr0, data0}, 41'(0));
      check("rh_flag", 40'({busy0, full0, done0, rdy0}), 40'(0));
      check("rh_cnt", 40'(cnt0), 40'(0));
      tick();
      check("rh_ce2", 40'(ce0), 40'(0));

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rdregs_word_packer.md
Name: rdregs_word_packer

Overview:
Write-side companion to the 256x32 / 512x16 register-readback SDPB buffer. Accepts a stream of 16-bit halfwords over a valid/ready handshake and packs pairs into 32-bit words. Drives the buffer's 32-bit write port (clock enable, word address, data), so the 16-bit read side later returns the halfwords in arrival order. Supports a programmable base address, partial-word flush, and full/wrap handling.

Parameters:
ADDR_W, 8, write-port word address width (buffer depth 2**ADDR_W words)
PAD, 16'h0000, fill value for the upper half on a flush of a partial word
WRAP, 0, 1 = address wraps to 0 after the last word; 0 = stop at full

Ports:
clk  in  1  single clock for all logic
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse: load base_addr, clear counters, begin a session
base_addr  in  ADDR_W  first word address of the session
in_valid  in  1  halfword available
in_data  in  16  halfword; first of a pair goes to bits [15:0]
in_ready  out  1  packer can accept in_data this cycle
flush  in  1  one-cycle pulse: close the session, writing any partial word
wr_ce  out  1  write strobe to the 32-bit port (one cycle per word)
wr_addr  out  ADDR_W  word address for wr_ce
wr_data  out  32  {high halfword, low halfword}
word_count  out  ADDR_W+1  words written since start
busy  out  1  session active (states LO, HI)
full  out  1  buffer full (WRAP=0 only)
done  out  1  one-cycle pulse at session end

Behaviour:
- Reset: state IDLE; in_ready=0, wr_ce=0, wr_addr=0, wr_data=0, word_count=0, busy=0, full=0, done=0; the partial-word latch is cleared.
- States: IDLE, LO (expecting the low half), HI (low half held, expecting the high half), FULL.
- Handshake: a halfword is transferred on a rising edge with in_valid & in_ready. in_ready = (state==LO | state==HI) & ~flush & ~start. This is combinational only from the state register, flush and start.
- start (any state): addr <= base_addr, word_count <= 0, full <= 0, partial latch discarded with no write, state <= LO. start has priority over flush and over data.
- LO + transfer: latch in_data as the low half; go to HI.
- HI + transfer:
  - Next cycle: wr_ce=1, wr_addr=addr, wr_data={in_data, low}.
  - addr increments, word_count increments, state returns to LO.
  - Throughput is 1 halfword/clock; write latency is 1 cycle after the second halfword.
- Address end: when a write uses addr = 2**ADDR_W-1:
  - WRAP=1: addr wraps to 0.
  - WRAP=0: state becomes FULL and full=1 in the same cycle as that wr_ce; in_ready=0.
- FULL: only start, flush or reset leave it. flush in FULL: done pulse next cycle, then IDLE, full cleared.
- flush in LO: no write; done=1 next cycle; state IDLE.
- flush in HI: next cycle wr_ce=1 with wr_data={PAD, low} at addr, word_count increments; done=1 the cycle after that wr_ce; state IDLE.
- flush in IDLE: ignored, no done.
- wr_ce, wr_addr, wr_data, done are registered. wr_addr and wr_data hold their last values when wr_ce=0.
- word_count saturates at 2**ADDR_W (WRAP=0). With WRAP=1 it wraps modulo 2**(ADDR_W+1).
- busy=1 in LO and HI only.
- reset mid-session: everything returns to reset values next cycle; a pending write in its output register is cancelled (wr_ce=0).

Test Plan:
- Reset then start with base_addr=0x10; stream 0x1111,0x2222,0x3333,0x4444 back-to-back -> wr_ce at addr 0x10 data 0x22221111, then at addr 0x11 data 0x44443333, each one cycle after the second half; word_count=2.
- After 3 halfwords (0xAAAA,0xBBBB,0xCCCC) pulse flush -> second write at addr+1 data 0x0000CCCC, done one cycle later, state IDLE, in_ready=0.
- WRAP=0, base_addr=0xFE, send 6 halfwords -> writes at 0xFE and 0xFF only; full=1 with the 0xFF write; 5th and 6th halfwords stall (in_ready=0); word_count=2.
- WRAP=1, base_addr=0xFF, send 4 halfwords -> writes at 0xFF then 0x00.
- in_valid toggling every other cycle -> same packed data and addresses as the back-to-back case; no spurious wr_ce.
- Mid-pair start (one halfword latched, then start with base_addr=0x40) -> no write of the orphan half; next pair lands at 0x40. Reset asserted during HI -> no wr_ce; all outputs at reset values.
